heap_feeder: RTL and testbench
==============================

HEAP_FEEDER -- requirements
Module: heap_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 31; sample MSB index, so samples are WIDTH+1 bits.
REQ-002 SHALL have parameter WINDOW_LENGTH, default 31; number of samples held in the sliding window.
REQ-003 SHALL have parameter FS_HIGH, default 2; number of cycles fs is held high per sample.
REQ-004 SHALL have parameter FS_PERIOD, default 8; minimum cycles between sample acceptances; legal only when FS_PERIOD >= FS_HIGH+2.
REQ-005 SHALL have port clk, input, 1 bit; clock.
REQ-006 SHALL have port rst, input, 1 bit; reset, synchronous, active-high.
REQ-007 SHALL have port in_valid, input, 1 bit; upstream sample present.
REQ-008 SHALL have port in_ready, output, 1 bit; block can accept a sample.
REQ-009 SHALL have port in_data, input, WIDTH+1 bits; upstream sample.
REQ-010 SHALL have port fs, output, 1 bit; sample strobe level to the sorter; the sorter detects its rising edge.
REQ-011 SHALL have port en_rec_in, output, 1 bit; records-enabled flag to the sorter.
REQ-012 SHALL have port data_in, output, WIDTH+1 bits; current sample presented to the sorter.
REQ-013 SHALL have port window_full, output, 1 bit; WINDOW_LENGTH samples are held.
REQ-014 SHALL have port sample_count, output, $clog2(WINDOW_LENGTH+1) bits; samples held, saturating.
REQ-015 SHALL have port evict_valid, output, 1 bit; one-cycle pulse marking an overwritten sample.
REQ-016 SHALL have port evict_data, output, WIDTH+1 bits; the sample leaving the window.

Function
REQ-017 SHALL implement an FSM with states IDLE, STROBE and GAP; in_ready SHALL equal (state==IDLE).
REQ-018 SHALL accept a sample on the edge where in_valid && in_ready (cycle 0), and on that edge SHALL:
- register in_data into data_in;
- write in_data to window RAM at wr_ptr;
- read the old entry at wr_ptr;
- go to STROBE.
REQ-019 SHALL hold fs at 1 in cycles 1..FS_HIGH (state STROBE), then go to GAP.
REQ-020 SHALL hold fs at 0 in cycles FS_HIGH+1..FS_PERIOD-1 (state GAP), then return to IDLE, so the next acceptance is no earlier than cycle FS_PERIOD.
REQ-021 SHALL hold data_in stable from acceptance until the next acceptance.
REQ-022 SHALL set en_rec_in to 1 on the first acceptance edge after reset and keep it at 1 until reset.
REQ-023 SHALL advance wr_ptr by 1 per acceptance and wrap from WINDOW_LENGTH-1 to 0.
REQ-024 SHALL increment sample_count per acceptance, saturating at WINDOW_LENGTH; window_full SHALL equal (sample_count==WINDOW_LENGTH).
REQ-025 SHALL, when window_full is 1 at acceptance, pulse evict_valid in cycle 1 with evict_data equal to the RAM entry overwritten in cycle 0.
REQ-026 SHALL NOT pulse evict_valid for acceptances made while window_full is 0.
REQ-027 SHALL treat in_valid outside IDLE as ignored: no acceptance, and in_data is not sampled.
REQ-028 SHALL give read-before-write ordering at wr_ptr in the same cycle: the old value is evicted and the new value is stored.

Reset
REQ-029 SHALL, on rst, set the state to IDLE, in_ready=1, fs=0, en_rec_in=0, data_in=0, wr_ptr=0, sample_count=0, window_full=0, evict_valid=0, evict_data=0.
REQ-030 SHALL, on rst mid-STROBE or mid-GAP, drive fs=0 on the next cycle and not complete the strobe.
REQ-031 SHALL NOT clear window RAM contents on reset; because sample_count is 0, no eviction occurs until the window refills.

Configuration
REQ-032 SHALL, with HEAP_FEEDER_EVICT_EN defined, implement the old-entry read and evict_valid/evict_data as specified above.
REQ-033 SHALL, without HEAP_FEEDER_EVICT_EN, keep the evict ports with evict_valid=0 and evict_data=0 constantly, remove the RAM read path, and leave all other behaviour unchanged.

Structure
REQ-034 SHALL place the FSM state enum (IDLE/STROBE/GAP) and the FS_PERIOD >= FS_HIGH+2 legality check in shared package heap_feeder_pkg.
REQ-035 SHALL hold window storage in one sub-module, heap_window_ram: WINDOW_LENGTH x (WIDTH+1), synchronous read, read-before-write on a single port.

Verification
REQ-036 SHALL verify reset behaviour: assert rst for 3 cycles, then release -> in_ready=1, fs=0, en_rec_in=0, sample_count=0.
REQ-037 SHALL verify strobe timing: with defaults, a single sample 0x0000_0005 -> data_in=5 from cycle 1, fs=1 in cycles 1-2, in_ready=1 again at cycle 8, en_rec_in=1 from cycle 1.
REQ-038 SHALL verify back-to-back throttling: in_valid held high continuously for 4 samples -> acceptances exactly 8 cycles apart and exactly 4 fs rising edges.
REQ-039 SHALL verify wrap and eviction (WINDOW_LENGTH=31, EVICT_EN defined): feed 1..32 -> window_full=1 after sample 31, and sample 32 gives evict_valid pulse with evict_data=1 while wr_ptr wraps to 0.
REQ-040 SHALL verify reset mid-strobe: assert rst in cycle 1 after acceptance -> fs=0 in cycle 2, then feed 31 fresh samples -> no evict_valid until sample 32.
REQ-041 SHALL verify the macro-off build: without HEAP_FEEDER_EVICT_EN, 40 samples -> evict_valid never 1, and fs/data_in timing identical to the macro-on build.

Source files
------------

// File: rtl/heap_feeder_pkg.sv
// Shared definitions for the heap feeder: FSM state encoding, strobe timing
// legality check and an address-width helper.
package heap_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        GAP    = 2'd2
    } feeder_state_t;

    // The strobe needs at least one high cycle and at least one low cycle
    // before the block returns to IDLE.
    function automatic bit fs_timing_legal(input int unsigned fs_high,
                                           input int unsigned fs_period);
        return (fs_high >= 1) && (fs_period >= fs_high + 2);
    endfunction

    // Index width for a table of the given depth, never less than one bit.
    function automatic int unsigned addr_bits(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/heap_window_ram.sv
// Sliding-window sample storage: DEPTH x (WIDTH+1), single port,
// synchronous read with read-before-write at the shared address.
// READ_EN=0 drops the read register; rd_data then reads as zero.
module heap_window_ram
    import heap_feeder_pkg::*;
#(
    parameter int WIDTH   = 31,
    parameter int DEPTH   = 31,
    parameter bit READ_EN = 1'b1
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [addr_bits(DEPTH)-1:0]  addr,
    input  logic [WIDTH:0]               wr_data,
    input  logic                         rd_en,
    output logic [WIDTH:0]               rd_data
);

    logic [WIDTH:0] mem [DEPTH];

    // Write port; contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

    if (READ_EN) begin : g_read
        // Registered read of the entry about to be overwritten (old value).
        always_ff @(posedge clk) begin
            if (rd_en) begin
                rd_data <= mem[addr];
            end
        end
    end else begin : g_no_read
        logic unused_sink;
        assign unused_sink = rd_en ^ (^mem[addr]);
        assign rd_data     = '0;
    end

endmodule

// File: rtl/heap_feeder.sv
// Heap feeder: accepts samples from a valid/ready source, presents each to
// the sorter with an fs strobe of FS_HIGH cycles and throttles acceptance to
// one per FS_PERIOD cycles, while tracking a WINDOW_LENGTH sliding window.
// Optional eviction reporting is enabled by defining HEAP_FEEDER_EVICT_EN.
module heap_feeder
    import heap_feeder_pkg::*;
#(
    parameter int WIDTH         = 31,
    parameter int WINDOW_LENGTH = 31,
    parameter int FS_HIGH       = 2,
    parameter int FS_PERIOD     = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [WIDTH:0]                         in_data,
    output logic                                   fs,
    output logic                                   en_rec_in,
    output logic [WIDTH:0]                         data_in,
    output logic                                   window_full,
    output logic [$clog2(WINDOW_LENGTH+1)-1:0]     sample_count,
    output logic                                   evict_valid,
    output logic [WIDTH:0]                         evict_data
);

    localparam int unsigned PTR_W = addr_bits(WINDOW_LENGTH);
    localparam int unsigned CNT_W = $clog2(WINDOW_LENGTH + 1);
    localparam int unsigned TMR_W = addr_bits(FS_PERIOD);

    if (!fs_timing_legal(FS_HIGH, FS_PERIOD)) begin : g_bad_timing
        $error("heap_feeder: FS_PERIOD must be >= FS_HIGH+2 and FS_HIGH >= 1");
    end

    feeder_state_t      state, state_next;
    logic [TMR_W-1:0]   tmr, tmr_next;
    logic [PTR_W-1:0]   wr_ptr;
    logic               accept;

    assign in_ready    = (state == IDLE);
    assign accept      = in_valid && in_ready;
    assign window_full = (sample_count == CNT_W'(WINDOW_LENGTH));

    // State and phase timer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tmr   <= '0;
        end else begin
            state <= state_next;
            tmr   <= tmr_next;
        end
    end

    // Next state: FS_HIGH cycles in STROBE, FS_PERIOD-FS_HIGH-1 in GAP.
    always_comb begin
        state_next = state;
        tmr_next   = tmr;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = STROBE;
                    tmr_next   = TMR_W'(FS_HIGH - 1);
                end
            end
            STROBE: begin
                if (tmr == '0) begin
                    state_next = GAP;
                    tmr_next   = TMR_W'(FS_PERIOD - FS_HIGH - 2);
                end else begin
                    tmr_next = tmr - TMR_W'(1);
                end
            end
            GAP: begin
                if (tmr == '0) begin
                    state_next = IDLE;
                end else begin
                    tmr_next = tmr - TMR_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered strobe so the sorter sees a clean level with no decode glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            fs <= 1'b0;
        end else begin
            fs <= (state_next == STROBE);
        end
    end

    // Sample capture, record enable, window pointer and fill count.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_in      <= '0;
            en_rec_in    <= 1'b0;
            wr_ptr       <= '0;
            sample_count <= '0;
        end else if (accept) begin
            data_in   <= in_data;
            en_rec_in <= 1'b1;
            wr_ptr    <= (wr_ptr == PTR_W'(WINDOW_LENGTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (!window_full) begin
                sample_count <= sample_count + CNT_W'(1);
            end
        end
    end

`ifdef HEAP_FEEDER_EVICT_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif

    logic [WIDTH:0] ram_rd_data;

    heap_window_ram #(
        .WIDTH   (WIDTH),
        .DEPTH   (WINDOW_LENGTH),
        .READ_EN (READ_EN)
    ) u_ram (
        .clk     (clk),
        .we      (accept),
        .addr    (wr_ptr),
        .wr_data (in_data),
        .rd_en   (accept),
        .rd_data (ram_rd_data)
    );

`ifdef HEAP_FEEDER_EVICT_EN
    // Eviction pulse one cycle after an acceptance into a full window.
    always_ff @(posedge clk) begin
        if (rst) begin
            evict_valid <= 1'b0;
        end else begin
            evict_valid <= accept && window_full;
        end
    end

    // The RAM read register is not reset; gating keeps evict_data at zero
    // outside the pulse, including straight after reset.
    assign evict_data = evict_valid ? ram_rd_data : '0;
`else
    logic ram_rd_unused;
    assign ram_rd_unused = ^ram_rd_data;
    assign evict_valid   = 1'b0;
    assign evict_data    = '0;
`endif

endmodule

// File: tb/tb_heap_feeder.sv
// Self-checking bench for heap_feeder with default parameters. Works with or
// without HEAP_FEEDER_EVICT_EN; expected samples and evictions come from a
// small window model and are checked from queues as the DUT produces them.
`timescale 1ns/1ps
module tb_heap_feeder;

    localparam int WIDTH     = 31;
    localparam int WL        = 31;
    localparam int FS_HIGH   = 2;
    localparam int FS_PERIOD = 8;

`ifdef HEAP_FEEDER_EVICT_EN
    localparam bit EVICT_ON = 1'b1;
`else
    localparam bit EVICT_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH:0]    in_data;
    logic              fs;
    logic              en_rec_in;
    logic [WIDTH:0]    data_in;
    logic              window_full;
    logic [$clog2(WL+1)-1:0] sample_count;
    logic              evict_valid;
    logic [WIDTH:0]    evict_data;

    always #5 clk = ~clk;

    heap_feeder #(
        .WIDTH         (WIDTH),
        .WINDOW_LENGTH (WL),
        .FS_HIGH       (FS_HIGH),
        .FS_PERIOD     (FS_PERIOD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .fs           (fs),
        .en_rec_in    (en_rec_in),
        .data_in      (data_in),
        .window_full  (window_full),
        .sample_count (sample_count),
        .evict_valid  (evict_valid),
        .evict_data   (evict_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Window model and scoreboard queues
    logic [WIDTH:0] model_mem [WL];
    int unsigned    model_ptr = 0;
    int unsigned    model_cnt = 0;
    logic [WIDTH:0] data_q[$];
    logic [WIDTH:0] evict_q[$];
    int             exp_evicts  = 0;
    int             seen_evicts = 0;
    int             rises       = 0;
    logic           fs_prev     = 1'b0;

    // Output monitor: every fs rise presents the next accepted sample, every
    // eviction pulse carries the next expected evicted sample.
    always @(negedge clk) begin
        if (fs === 1'b1 && fs_prev === 1'b0) begin
            rises++;
            if (data_q.size() == 0) check("fs_rise_expected", data_q.size(), 1);
            else                    check("data_in", data_in, data_q.pop_front());
        end
        fs_prev = fs;
        if (evict_valid === 1'b1) begin
            seen_evicts++;
            if (evict_q.size() == 0) check("evict_expected", evict_q.size(), 1);
            else                     check("evict_data", evict_data, evict_q.pop_front());
        end
    end

    // Enter at a negedge; returns at the negedge of cycle 1 after acceptance.
    task automatic send(input logic [WIDTH:0] d, output time acc_t);
        int unsigned n = 0;
        acc_t    = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            check("accept_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        acc_t = $time;
        data_q.push_back(d);
        if (EVICT_ON && model_cnt == WL) begin
            evict_q.push_back(model_mem[model_ptr]);
            exp_evicts++;
        end
        model_mem[model_ptr] = d;
        model_ptr = (model_ptr == WL - 1) ? 0 : model_ptr + 1;
        if (model_cnt < WL) model_cnt++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst       = 1'b0;
        model_ptr = 0;
        model_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        time t;
        time tb2b [4];
        int  r0;

        rst = 1'b1; in_valid = 1'b0; in_data = '0;

        // Reset state
        do_reset();
        check("rst_in_ready", in_ready, 1);
        check("rst_fs", fs, 0);
        check("rst_en_rec", en_rec_in, 0);
        check("rst_count", sample_count, 0);
        check("rst_full", window_full, 0);
        check("rst_evict", evict_valid, 0);
        check("rst_data_in", data_in, 0);
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);

        // Single sample strobe timing
        send(32'h0000_0005, t);
        in_valid = 1'b0;
        check("c1_data_in", data_in, 5);
        check("c1_fs", fs, 1);
        check("c1_en_rec", en_rec_in, 1);
        check("c1_in_ready", in_ready, 0);
        @(negedge clk);
        check("c2_fs", fs, 1);
        @(negedge clk);
        check("c3_fs", fs, 0);
        for (int c = 4; c <= 7; c++) begin
            @(negedge clk);
            check("gap_in_ready", in_ready, 0);
            check("gap_fs", fs, 0);
        end
        @(negedge clk);
        check("c8_in_ready", in_ready, 1);
        check("c8_data_hold", data_in, 5);
        check("c8_en_rec", en_rec_in, 1);

        // Back-to-back throttling with in_valid held high
        r0 = rises;
        for (int i = 0; i < 4; i++) send(32'h0000_0006 + i, tb2b[i]);
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++) check("b2b_interval", 64'((tb2b[i] - tb2b[i-1]) / 10), 8);
        repeat (10) @(negedge clk);
        check("b2b_rises", rises - r0, 4);

        // Fill, wrap and eviction from a fresh window
        do_reset();
        for (int v = 1; v <= 40; v++) begin
            send(v, t);
            in_valid = 1'b0;
            if (v == 30) check("full_at_30", window_full, 0);
            if (v == 31) begin
                check("full_at_31", window_full, 1);
                check("count_at_31", sample_count, 31);
                check("wr_ptr_wrap", dut.wr_ptr, 0);
                check("no_evict_31", evict_valid, 0);
            end
            if (v == 32) begin
                check("evict_at_32", evict_valid, EVICT_ON);
                check("wr_ptr_after_32", dut.wr_ptr, 1);
                check("count_sat", sample_count, 31);
            end
        end

        // Reset during the strobe, then refill
        send(32'h0000_004D, t);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_fs", fs, 0);
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
        model_cnt = 0;
        check("rst_mid_count", sample_count, 0);
        check("rst_mid_en_rec", en_rec_in, 0);
        for (int v = 101; v <= 132; v++) begin
            send(v, t);
            in_valid = 1'b0;
            if (v < 132) check("refill_no_evict", evict_valid, 0);
            else         check("refill_evict_32", evict_valid, EVICT_ON);
        end

        repeat (12) @(negedge clk);
        check("data_q_drained", data_q.size(), 0);
        check("evict_q_drained", evict_q.size(), 0);
        check("evict_count", seen_evicts, exp_evicts);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
